recirculation_ctrl: RTL and testbench

- Generates the select (active) for the per-lane recirculation demultiplexers that sit ahead of the byte-striping stage in the PCIe interface.
- Data recirculates back to its source block until every lane presents valid data and the striping stage is ready.
- Once both conditions hold, the lanes are released together.
- A recirculation watchdog flags stalled lanes.

---
 rtl/recirculation_ctrl.sv | 155 +++++++++++++++
 tb/tb_recirculation_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/recirculation_ctrl.sv
// rtl/recirculation_ctrl.sv - recirculation select generator with stall watchdog
//
// Drives the select of the per-lane recirculation demuxes ahead of byte striping.
// Lanes recirculate until every lane is valid and the striping stage is ready,
// then they are released together. A watchdog flags lanes that stall too long.
//
// Optional feature macro: RECIRC_STATS_EN (adds stall_total / stats_clr).
//
// Ports:
//   clk           system clock, rising edge
//   reset_L       asynchronous active-low reset
//   valid_in      per-lane data-valid [LANES-1:0]
//   stripe_ready  striping stage accepts a beat this cycle
//   clear_err     pulse; clears the timeout (only acts in ERROR)
//   active        registered select: 1 forward, 0 recirculate
//   recirc_cnt    consecutive cycles spent in RECIRC [CNT_W-1:0]
//   timeout_err   sticky watchdog error
//   state_o       current state encoding (debug)
//   stall_total   (RECIRC_STATS_EN) saturating count of RECIRC/ERROR cycles
//   stats_clr     (RECIRC_STATS_EN) synchronous clear of stall_total

module recirculation_ctrl #(
    parameter int LANES      = 4,
    parameter int MAX_RECIRC = 15,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic [LANES-1:0] valid_in,
    input  logic             stripe_ready,
    input  logic             clear_err,
`ifdef RECIRC_STATS_EN
    input  logic             stats_clr,
    output logic [15:0]      stall_total,
`endif
    output logic             active,
    output logic [CNT_W-1:0] recirc_cnt,
    output logic             timeout_err,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECIRC = 2'd1,
        ACTIVE = 2'd2,
        ERROR  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_RECIRC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_RECIRC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t state;

    logic all_v;
    logic any_v;
    logic release_ok;

    assign all_v      = &valid_in;
    assign any_v      = |valid_in;
    assign release_ok = all_v & stripe_ready;
    assign state_o    = state;

    // Entering RECIRC counts that first cycle, so recirc_cnt reads 1 during the
    // first recirculating cycle. The >= compare keeps the counter from running
    // past MAX_RECIRC even in the degenerate MAX_RECIRC=1 configuration.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state       <= IDLE;
            active      <= 1'b0;
            recirc_cnt  <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (release_ok) begin
                        state      <= ACTIVE;
                        active     <= 1'b1;
                        recirc_cnt <= '0;
                    end else if (any_v) begin
                        state      <= RECIRC;
                        active     <= 1'b0;
                        recirc_cnt <= CNT_ONE;
                    end else begin
                        active     <= 1'b0;
                        recirc_cnt <= '0;
                    end
                end
                RECIRC: begin
                    if (release_ok) begin
                        // release wins over a coincident timeout
                        state      <= ACTIVE;
                        active     <= 1'b1;
                        recirc_cnt <= '0;
                    end else if (recirc_cnt >= CNT_LAST) begin
                        state       <= ERROR;
                        active      <= 1'b0;
                        recirc_cnt  <= CNT_MAX;
                        timeout_err <= 1'b1;
                    end else if (!any_v) begin
                        state      <= IDLE;
                        active     <= 1'b0;
                        recirc_cnt <= '0;
                    end else begin
                        active     <= 1'b0;
                        recirc_cnt <= recirc_cnt + CNT_ONE;
                    end
                end
                ACTIVE: begin
                    if (release_ok) begin
                        active     <= 1'b1;
                        recirc_cnt <= '0;
                    end else if (!any_v) begin
                        state      <= IDLE;
                        active     <= 1'b0;
                        recirc_cnt <= '0;
                    end else begin
                        state      <= RECIRC;
                        active     <= 1'b0;
                        recirc_cnt <= CNT_ONE;
                    end
                end
                ERROR: begin
                    active <= 1'b0;
                    if (clear_err) begin
                        state       <= IDLE;
                        recirc_cnt  <= '0;
                        timeout_err <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    active      <= 1'b0;
                    recirc_cnt  <= '0;
                    timeout_err <= 1'b0;
                end
            endcase
        end
    end

`ifdef RECIRC_STATS_EN
    // Counts cycles the lanes are held back (RECIRC or ERROR); a clear in the
    // same cycle as an increment wins.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            stall_total <= '0;
        end else if (stats_clr) begin
            stall_total <= '0;
        end else if ((state == RECIRC || state == ERROR) && stall_total != 16'hFFFF) begin
            stall_total <= stall_total + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_recirculation_ctrl.sv
// tb/tb_recirculation_ctrl.sv - self-checking bench for recirculation_ctrl
module tb_recirculation_ctrl;

    localparam int LANES      = 4;
    localparam int MAX_RECIRC = 15;
    localparam int CNT_W      = 4;

    logic             clk;
    logic             reset_L;
    logic [LANES-1:0] valid_in;
    logic             stripe_ready;
    logic             clear_err;
    logic             active;
    logic [CNT_W-1:0] recirc_cnt;
    logic             timeout_err;
    logic [1:0]       state_o;
`ifdef RECIRC_STATS_EN
    logic             stats_clr;
    logic [15:0]      stall_total;
`endif

    int checks = 0;
    int errors = 0;

    recirculation_ctrl #(
        .LANES(LANES), .MAX_RECIRC(MAX_RECIRC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset_L(reset_L),
        .valid_in(valid_in),
        .stripe_ready(stripe_ready),
        .clear_err(clear_err),
`ifdef RECIRC_STATS_EN
        .stats_clr(stats_clr),
        .stall_total(stall_total),
`endif
        .active(active),
        .recirc_cnt(recirc_cnt),
        .timeout_err(timeout_err),
        .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode is 0 idle, 1 held back, 2 forwarding, 3 faulted;
    // run is the length of the current hold-back streak.
    int m_mode = 0;
    int m_run  = 0;
    int m_err  = 0;
    int m_stall = 0;

    always @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            m_mode = 0; m_run = 0; m_err = 0; m_stall = 0;
        end else begin
            bit every, some, go, held;
            every = (valid_in == '1);
            some  = (valid_in != '0);
            go    = every && stripe_ready;
            held  = (m_mode == 1 || m_mode == 3);
`ifdef RECIRC_STATS_EN
            if (stats_clr) m_stall = 0;
            else if (held) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
`endif
            if (m_mode == 3) begin
                if (clear_err) begin m_mode = 0; m_run = 0; m_err = 0; end
            end else if (go) begin
                m_mode = 2; m_run = 0;
            end else if (m_mode == 1 && m_run + 1 >= MAX_RECIRC) begin
                m_mode = 3; m_run = MAX_RECIRC; m_err = 1;
            end else if (!some) begin
                m_mode = 0; m_run = 0;
            end else begin
                m_run  = (m_mode == 1) ? m_run + 1 : 1;
                m_mode = 1;
            end
        end
    end

    // Single compare process: outputs settle well before the falling edge.
    always @(negedge clk) begin
        check("active",      int'(active),      (m_mode == 2) ? 1 : 0);
        check("recirc_cnt",  int'(recirc_cnt),  m_run);
        check("timeout_err", int'(timeout_err), m_err);
        check("state_o",     int'(state_o),     m_mode);
`ifdef RECIRC_STATS_EN
        check("stall_total", int'(stall_total), m_stall);
`endif
    end

    // Drive inputs just after a falling edge, hold for n cycles, end on a falling edge.
    task automatic apply(input logic [LANES-1:0] v, input logic sr, input logic ce, input int n);
        valid_in = v; stripe_ready = sr; clear_err = ce;
        repeat (n) @(negedge clk);
        #1;
    endtask

    int stall_before;

    initial begin
        reset_L = 1'b0; valid_in = '0; stripe_ready = 1'b0; clear_err = 1'b0;
        stall_before = 0;
`ifdef RECIRC_STATS_EN
        stats_clr = 1'b0;
`endif
        // reset with random inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            valid_in = LANES'($urandom); stripe_ready = 1'($urandom); clear_err = 1'($urandom);
        end
        @(negedge clk); #1;
        check("rst_active", int'(active), 0);
        check("rst_state",  int'(state_o), 0);
        reset_L = 1'b1;

        // direct release, then drop to idle
        apply(4'hF, 1'b1, 1'b0, 1);
        check("rel_active", int'(active), 1);
        check("rel_cnt",    int'(recirc_cnt), 0);
        apply(4'h0, 1'b1, 1'b0, 1);
        check("idle_active", int'(active), 0);
        check("idle_state",  int'(state_o), 0);

        // partial valid for 5 cycles, then release
        apply(4'b0111, 1'b1, 1'b0, 5);
        check("part_cnt5", int'(recirc_cnt), 5);
        apply(4'hF, 1'b1, 1'b0, 1);
        check("part_rel",  int'(active), 1);
        check("part_cnt0", int'(recirc_cnt), 0);
        apply(4'h0, 1'b0, 1'b0, 1);

        // timeout, inputs ignored in ERROR, clear
        apply(4'b0001, 1'b0, 1'b0, 14);
        check("to_pre_state", int'(state_o), 1);
        check("to_pre_cnt",   int'(recirc_cnt), 14);
        apply(4'b0001, 1'b0, 1'b0, 1);
        check("to_err",   int'(timeout_err), 1);
        check("to_state", int'(state_o), 3);
        check("to_cnt",   int'(recirc_cnt), 15);
        apply(4'hF, 1'b1, 1'b0, 3);
        check("to_no_active", int'(active), 0);
        check("to_hold_cnt",  int'(recirc_cnt), 15);
        apply(4'hF, 1'b1, 1'b1, 1);
        check("clr_state", int'(state_o), 0);
        check("clr_err",   int'(timeout_err), 0);
        apply(4'h0, 1'b0, 1'b0, 1);

        // release coincident with last count before timeout
        apply(4'b1011, 1'b1, 1'b0, 14);
        check("sim_cnt14", int'(recirc_cnt), 14);
        apply(4'hF, 1'b1, 1'b0, 1);
        check("sim_state", int'(state_o), 2);
        check("sim_err",   int'(timeout_err), 0);

        // backpressure from ACTIVE
`ifdef RECIRC_STATS_EN
        stall_before = int'(stall_total);
`endif
        apply(4'hF, 1'b0, 1'b0, 1);
        check("bp_active1", int'(active), 0);
        check("bp_cnt1",    int'(recirc_cnt), 1);
        apply(4'hF, 1'b0, 1'b0, 1);
        check("bp_cnt2",    int'(recirc_cnt), 2);
        apply(4'hF, 1'b1, 1'b0, 1);
        check("bp_active",  int'(active), 1);
`ifdef RECIRC_STATS_EN
        check("bp_stall_delta", int'(stall_total) - stall_before, 2);
`endif

        // clear_err outside ERROR has no effect
        apply(4'hF, 1'b1, 1'b1, 2);
        check("ce_noeffect", int'(state_o), 2);

`ifdef RECIRC_STATS_EN
        // stats clear while stalled wins over increment
        apply(4'b0011, 1'b1, 1'b0, 2);
        stats_clr = 1'b1;
        apply(4'b0011, 1'b1, 1'b0, 1);
        stats_clr = 1'b0;
        check("stats_clr", int'(stall_total), 0);
        apply(4'hF, 1'b1, 1'b0, 1);
`endif

        // asynchronous reset mid-ACTIVE
        check("pre_rst_active", int'(active), 1);
        #2;
        reset_L = 1'b0;
        #1;
        check("async_active", int'(active), 0);
        check("async_state",  int'(state_o), 0);
        apply(4'hF, 1'b1, 1'b0, 2);
        check("held_rst_active", int'(active), 0);
        reset_L = 1'b1;
        apply(4'hF, 1'b1, 1'b0, 1);
        check("post_rst_active", int'(active), 1);
        apply(4'h0, 1'b0, 1'b0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
